// File: rtl/ifid_front_ctrl_if.sv
// ifid_front_ctrl_if
//   Bundles the fetch-control signals between the hazard/branch logic,
//   instruction memory, the decode stage and ifid_front_ctrl.
//   Parameters: N  - PC / instruction width
//               CW - stall counter width
//   Modports:
//     slave  - the fetch controller: samples requests and imem_instr,
//              drives pc, IF/ID contents and stall status.
//     master - the surrounding pipeline (or a bench): the reverse view.
interface ifid_front_ctrl_if #(
    parameter int N  = 32,
    parameter int CW = 4
);
    logic          stall_req;
    logic          flush_req;
    logic [N-1:0]  redirect_pc;
    logic [N-1:0]  imem_instr;
    logic [N-1:0]  pc;
    logic [N-1:0]  ifid_pc;
    logic [N-1:0]  ifid_instr;
    logic          ifid_valid;
    logic [CW-1:0] stall_cnt;
    logic          stall_timeout;

    modport slave (
        input  stall_req, flush_req, redirect_pc, imem_instr,
        output pc, ifid_pc, ifid_instr, ifid_valid, stall_cnt, stall_timeout
    );

    modport master (
        output stall_req, flush_req, redirect_pc, imem_instr,
        input  pc, ifid_pc, ifid_instr, ifid_valid, stall_cnt, stall_timeout
    );
endinterface

// File: rtl/ifid_front_ctrl.sv
// ifid_front_ctrl
//   Fetch-side controller: owns the PC and the IF/ID pipeline register and
//   applies the hazard/branch action each cycle (flush > stall > advance).
//   Flush loads a word-aligned redirect target and inserts a NOP bubble;
//   stall holds PC and IF/ID; advance latches the fetched instruction and
//   steps PC by 4. Consecutive stalls are counted (saturating) and a sticky
//   timeout flag is raised when a stall outlasts MAX_STALL.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - ifid_front_ctrl_if.slave
//              in : stall_req, flush_req, redirect_pc, imem_instr
//              out: pc, ifid_pc, ifid_instr, ifid_valid,
//                   stall_cnt, stall_timeout (all registered)
module ifid_front_ctrl #(
    parameter int          N         = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP       = 32'h0000_0013,
    parameter int          MAX_STALL = 15,
    parameter int          CW        = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    ifid_front_ctrl_if.slave   bus
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  pc_q;
    logic [N-1:0]  ifid_pc_q;
    logic [N-1:0]  ifid_instr_q;
    logic          ifid_valid_q;
    logic [CW-1:0] stall_cnt_q;
    logic          stall_timeout_q;

    logic do_flush;
    logic do_stall;
    logic cnt_at_max;

    // Flush wins over stall, so a stall only counts when no flush is present.
    assign do_flush   = bus.flush_req;
    assign do_stall   = bus.stall_req & ~bus.flush_req;
    assign cnt_at_max = (stall_cnt_q == CW'(MAX_STALL));

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (do_stall)  state_d = STALL;
            STALL:   if (!do_stall) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= RUN;
            pc_q            <= N'(RESET_PC);
            ifid_pc_q       <= '0;
            ifid_instr_q    <= N'(NOP);
            ifid_valid_q    <= 1'b0;
            stall_cnt_q     <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (do_flush) begin
                // Redirect target is forced word-aligned.
                pc_q         <= {bus.redirect_pc[N-1:2], 2'b00};
                ifid_pc_q    <= '0;
                ifid_instr_q <= N'(NOP);
                ifid_valid_q <= 1'b0;
                stall_cnt_q  <= '0;
            end else if (do_stall) begin
                // Timeout fires on the first stall edge seen at saturation.
                if (cnt_at_max) begin
                    stall_timeout_q <= 1'b1;
                end else begin
                    stall_cnt_q <= stall_cnt_q + CW'(1);
                end
            end else begin
                ifid_pc_q    <= pc_q;
                ifid_instr_q <= bus.imem_instr;
                ifid_valid_q <= 1'b1;
                pc_q         <= pc_q + N'(4);
                stall_cnt_q  <= '0;
            end
        end
    end

    assign bus.pc            = pc_q;
    assign bus.ifid_pc       = ifid_pc_q;
    assign bus.ifid_instr    = ifid_instr_q;
    assign bus.ifid_valid    = ifid_valid_q;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_ifid_front_ctrl.sv
module tb_ifid_front_ctrl;
    localparam int          N         = 32;
    localparam int          CW        = 4;
    localparam int          MAX_STALL = 15;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ifid_front_ctrl_if #(.N(N), .CW(CW)) bus ();

    ifid_front_ctrl #(
        .N(N), .RESET_PC(RESET_PC), .NOP(NOP), .MAX_STALL(MAX_STALL), .CW(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic        valid;
        logic [3:0]  cnt;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_ipc, m_instr;
    logic        m_valid, m_to;
    logic [3:0]  m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_snap();
        exp_t e;
        e.pc = m_pc; e.ipc = m_ipc; e.instr = m_instr;
        e.valid = m_valid; e.cnt = m_cnt; e.to = m_to;
        return e;
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_ipc = '0; m_instr = NOP;
        m_valid = 1'b0; m_cnt = '0; m_to = 1'b0;
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_pc"},    bus.pc,                     e.pc);
        chk({tag, "_ipc"},   bus.ifid_pc,                e.ipc);
        chk({tag, "_instr"}, bus.ifid_instr,             e.instr);
        chk({tag, "_valid"}, {31'b0, bus.ifid_valid},    {31'b0, e.valid});
        chk({tag, "_cnt"},   {28'b0, bus.stall_cnt},     {28'b0, e.cnt});
        chk({tag, "_to"},    {31'b0, bus.stall_timeout}, {31'b0, e.to});
    endtask

    // Drive one cycle of requests, predict the post-edge state, then check it.
    task automatic step(input logic stall, input logic flush,
                        input logic [31:0] redir, input logic [31:0] instr,
                        input string tag);
        bus.stall_req   = stall;
        bus.flush_req   = flush;
        bus.redirect_pc = redir;
        bus.imem_instr  = instr;
        if (flush) begin
            m_pc = {redir[31:2], 2'b00};
            m_instr = NOP; m_valid = 1'b0; m_ipc = '0; m_cnt = '0;
        end else if (stall) begin
            if (m_cnt == 4'(MAX_STALL)) m_to = 1'b1;
            else m_cnt = m_cnt + 4'd1;
        end else begin
            m_ipc = m_pc; m_instr = instr; m_valid = 1'b1;
            m_pc = m_pc + 32'd4; m_cnt = '0;
        end
        sb.push_back(model_snap());
        @(posedge clk);
        #1;
        check_pop(tag);
    endtask

    initial begin
        bus.stall_req   = 1'b0;
        bus.flush_req   = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_instr  = '0;

        // Reset values while rst_n is low
        #12;
        model_reset();
        sb.push_back(model_snap());
        check_pop("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Three advances: A, B, C
        step(0, 0, 0, 32'hAAAA_0001, "adv_a");
        step(0, 0, 0, 32'hBBBB_0002, "adv_b");
        step(0, 0, 0, 32'hCCCC_0003, "adv_c");
        chk("abc_pc",    bus.pc,         32'h0000_000C);
        chk("abc_ipc",   bus.ifid_pc,    32'h0000_0008);
        chk("abc_instr", bus.ifid_instr, 32'hCCCC_0003);
        chk("abc_valid", {31'b0, bus.ifid_valid}, 32'd1);

        // pc=0x10, IF/ID={0x0C,D}; two stalls then advance
        step(0, 0, 0, 32'hDDDD_0004, "adv_d");
        step(1, 0, 0, 32'h1234_5678, "stall1");
        step(1, 0, 0, 32'h8765_4321, "stall2");
        chk("stall_pc",    bus.pc,         32'h0000_0010);
        chk("stall_ipc",   bus.ifid_pc,    32'h0000_000C);
        chk("stall_instr", bus.ifid_instr, 32'hDDDD_0004);
        chk("stall_cnt2",  {28'b0, bus.stall_cnt}, 32'd2);
        step(0, 0, 0, 32'hEEEE_0005, "adv_e");
        chk("post_stall_ipc", bus.ifid_pc, 32'h0000_0010);
        chk("post_stall_cnt", {28'b0, bus.stall_cnt}, 32'd0);

        // Flush with stall also asserted; misaligned redirect
        step(1, 0, 0, 32'h0, "pre_flush_stall");
        step(1, 1, 32'h0000_0203, 32'h0, "flush");
        chk("flush_pc",    bus.pc,         32'h0000_0200);
        chk("flush_instr", bus.ifid_instr, 32'h0000_0013);
        chk("flush_valid", {31'b0, bus.ifid_valid}, 32'd0);
        chk("flush_cnt",   {28'b0, bus.stall_cnt}, 32'd0);

        // 17-edge stall: saturation and sticky timeout
        step(0, 0, 0, 32'h0BAD_F00D, "adv_pre_sat");
        for (int i = 0; i < 17; i++) begin
            step(1, 0, 0, $urandom, "sat");
            if (i == 14) begin
                chk("sat15_cnt", {28'b0, bus.stall_cnt}, 32'd15);
                chk("sat15_to",  {31'b0, bus.stall_timeout}, 32'd0);
            end
            if (i == 15) chk("sat16_to", {31'b0, bus.stall_timeout}, 32'd1);
        end
        step(0, 0, 0, 32'h600D_0001, "release");
        chk("to_sticky", {31'b0, bus.stall_timeout}, 32'd1);
        chk("release_cnt", {28'b0, bus.stall_cnt}, 32'd0);

        // PC wrap
        step(0, 1, 32'hFFFF_FFFF, 32'h0, "flush_top");
        chk("flush_top_pc", bus.pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 32'hCAFE_0001, "wrap");
        chk("wrap_pc",  bus.pc,      32'h0000_0000);
        chk("wrap_ipc", bus.ifid_pc, 32'hFFFF_FFFC);

        // Mixed request patterns
        for (int i = 0; i < 24; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 $urandom, $urandom, "mix");
        end

        // Async reset mid-stall
        step(1, 0, 0, 32'h0, "pre_rst_stall1");
        step(1, 0, 0, 32'h0, "pre_rst_stall2");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        sb.push_back(model_snap());
        check_pop("async_rst");
        @(negedge clk);
        bus.stall_req = 1'b0;
        rst_n = 1'b1;
        step(0, 0, 0, 32'h1111_2222, "first_after_rst");
        chk("far_ipc",   bus.ifid_pc,    RESET_PC);
        chk("far_pc",    bus.pc,         RESET_PC + 32'd4);
        chk("far_instr", bus.ifid_instr, 32'h1111_2222);

        if (sb.size() != 0) chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
